// File: rtl/ultrasonic_ranger_if.sv
// ultrasonic_ranger_if: enable control and range result bus between the ranger and its consumers.
interface ultrasonic_ranger_if #(parameter int CM_W = 16);
    logic            enable;
    logic [CM_W-1:0] distance_cm;
    logic            valid;
    logic            timeout;
    logic            out_of_range;
    logic            busy;
    modport master (output enable, input distance_cm, valid, timeout, out_of_range, busy);
    modport slave (input enable, output distance_cm, valid, timeout, out_of_range, busy);
endinterface

// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger: HC-SR04 style periodic trigger and echo-width range finder.
// Define ULTRASONIC_AVG_EN to report a moving average of the last 4 accepted results.
module ultrasonic_ranger #(
    parameter int TRIG_CYCLES    = 500,
    parameter int PERIOD_CYCLES  = 5000000,
    parameter int CYCLES_PER_CM  = 2900,
    parameter int ECHO_TO_CYCLES = 1500000,
    parameter int MAX_CM         = 400,
    parameter int CM_W           = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               echo,
    output logic               trigger,
    ultrasonic_ranger_if.slave rng
);
    localparam int PC_W  = $clog2(PERIOD_CYCLES + 1);
    localparam int CNT_W = $clog2((TRIG_CYCLES > ECHO_TO_CYCLES ? TRIG_CYCLES : ECHO_TO_CYCLES) + 1);
    localparam int SUB_W = $clog2(CYCLES_PER_CM + 1);
    typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, DONE} state_t;
    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic [CM_W-1:0]   cm_q, cm_d;
    logic [CM_W-1:0]   distance_q, distance_d;
    logic              valid_q, valid_d;
    logic              timeout_q, timeout_d;
    logic              oor_q, oor_d;
    logic              trigger_q, trigger_d;
    logic              busy_q, busy_d;
    logic              echo_m_q, echo_s_q, echo_dly_q;
    logic              rise, fall;
`ifdef ULTRASONIC_AVG_EN
    logic [CM_W-1:0]   hist_q [4];
    logic [CM_W-1:0]   hist_d [4];
    logic              have_q, have_d;
    logic [CM_W+1:0]   sum;
`endif
    assign rise = echo_s_q & ~echo_dly_q;
    assign fall = ~echo_s_q & echo_dly_q;
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sub_d      = sub_q;
        cm_d       = cm_q;
        distance_d = distance_q;
        oor_d      = oor_q;
        valid_d    = 1'b0;
        timeout_d  = 1'b0;
        pc_d       = (!rng.enable || pc_q == PC_W'(PERIOD_CYCLES - 1)) ? '0 : pc_q + PC_W'(1);
`ifdef ULTRASONIC_AVG_EN
        hist_d     = hist_q;
        have_d     = have_q;
        sum        = '0;
`endif
        if (!rng.enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (pc_q == '0) begin
                    state_d = TRIG;
                    cnt_d   = '0;
                end
                TRIG: if (cnt_q == CNT_W'(TRIG_CYCLES - 1)) begin
                    state_d = WAIT_ECHO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                WAIT_ECHO: if (rise) begin
                    state_d = MEASURE;
                    sub_d   = '0;
                    cm_d    = '0;
                end else if (cnt_q == CNT_W'(ECHO_TO_CYCLES - 1)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                MEASURE: begin
                    // The delayed copy is high for exactly the echo-high cycles, rise cycle included.
                    if (echo_dly_q) begin
                        sub_d = (sub_q == SUB_W'(CYCLES_PER_CM - 1)) ? '0 : sub_q + SUB_W'(1);
                        cm_d  = (sub_q == SUB_W'(CYCLES_PER_CM - 1) && cm_q != CM_W'(MAX_CM)) ? cm_q + CM_W'(1) : cm_q;
                    end
                    if (fall) state_d = DONE;
                end
                DONE: begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    oor_d   = (cm_q == CM_W'(MAX_CM));
`ifdef ULTRASONIC_AVG_EN
                    sum        = have_q ? {2'b00, cm_q} + {2'b00, hist_q[0]} + {2'b00, hist_q[1]} + {2'b00, hist_q[2]}
                                        : {cm_q, 2'b00};
                    hist_d     = have_q ? '{cm_q, hist_q[0], hist_q[1], hist_q[2]} : '{cm_q, cm_q, cm_q, cm_q};
                    have_d     = 1'b1;
                    distance_d = sum[CM_W+1:2];
`else
                    distance_d = cm_q;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
        trigger_d = (state_d == TRIG);
        busy_d    = (state_d != IDLE);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            cnt_q      <= '0;
            sub_q      <= '0;
            cm_q       <= '0;
            distance_q <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            oor_q      <= 1'b0;
            trigger_q  <= 1'b0;
            busy_q     <= 1'b0;
            echo_m_q   <= 1'b0;
            echo_s_q   <= 1'b0;
            echo_dly_q <= 1'b0;
`ifdef ULTRASONIC_AVG_EN
            hist_q     <= '{default: '0};
            have_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            sub_q      <= sub_d;
            cm_q       <= cm_d;
            distance_q <= distance_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
            oor_q      <= oor_d;
            trigger_q  <= trigger_d;
            busy_q     <= busy_d;
            echo_m_q   <= echo;
            echo_s_q   <= echo_m_q;
            echo_dly_q <= echo_s_q;
`ifdef ULTRASONIC_AVG_EN
            hist_q     <= hist_d;
            have_q     <= have_d;
`endif
        end
    end
    assign trigger          = trigger_q;
    assign rng.distance_cm  = distance_q;
    assign rng.valid        = valid_q;
    assign rng.timeout      = timeout_q;
    assign rng.out_of_range = oor_q;
    assign rng.busy         = busy_q;
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb_ultrasonic_ranger: directed checks of trigger timing, echo measurement, timeout and abort paths.
module tb_ultrasonic_ranger;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic echo = 1'b0;
    logic trigger;
    int   checks = 0;
    int   failures = 0;
    int   n;
    ultrasonic_ranger_if #(.CM_W(16)) rng ();
    ultrasonic_ranger #(
        .TRIG_CYCLES(5), .PERIOD_CYCLES(2000), .CYCLES_PER_CM(10),
        .ECHO_TO_CYCLES(300), .MAX_CM(100), .CM_W(16)
    ) dut (
        .clk(clk), .reset(reset), .echo(echo), .trigger(trigger), .rng(rng)
    );
    always #5 clk = ~clk;
`ifdef ULTRASONIC_AVG_EN
    localparam int SAT_CM = 43, SHORT_CM = 38;
    localparam int AVG_CM [4] = '{10, 12, 17, 25};
`else
    localparam int SAT_CM = 100, SHORT_CM = 5;
    localparam int AVG_CM [4] = '{10, 20, 30, 40};
`endif
    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic wait_trig(input string tag, input int exp);
        n = 0;
        while (!trigger && n < 3000) begin
            tick(1);
            n++;
        end
        chk(tag, n, exp);
    endtask
    task automatic measure(input string tag, input int len, input int exp_cm, input logic exp_oor);
        tick(5);
        chk({tag, "_trig_low"}, trigger, 1'b0);
        echo = 1'b1;
        tick(len);
        echo = 1'b0;
        tick(3);
        chk({tag, "_valid_early"}, rng.valid, 1'b0);
        tick(1);
        chk({tag, "_valid"}, rng.valid, 1'b1);
        chk({tag, "_dist"}, rng.distance_cm, exp_cm);
        chk({tag, "_oor"}, rng.out_of_range, exp_oor);
    endtask
    initial begin
        rng.enable = 1'b0;
        tick(3);
        chk("rst_trigger", trigger, 1'b0);
        chk("rst_dist", rng.distance_cm, 0);
        chk("rst_valid", rng.valid, 1'b0);
        chk("rst_timeout", rng.timeout, 1'b0);
        chk("rst_oor", rng.out_of_range, 1'b0);
        chk("rst_busy", rng.busy, 1'b0);
        reset = 1'b0;
        rng.enable = 1'b1;
        wait_trig("t1_first_trig", 1);
        chk("t1_busy", rng.busy, 1'b1);
        n = 0;
        while (trigger && n < 50) begin
            n++;
            tick(1);
        end
        chk("t1_trig_len", n, 5);
        echo = 1'b1;
        tick(250);
        echo = 1'b0;
        tick(3);
        chk("t1_valid_early", rng.valid, 1'b0);
        tick(1);
        chk("t1_valid", rng.valid, 1'b1);
        chk("t1_dist", rng.distance_cm, 25);
        chk("t1_oor", rng.out_of_range, 1'b0);
        tick(1);
        chk("t1_valid_pulse", rng.valid, 1'b0);
        wait_trig("t2_trig_gap", 1740);
        tick(5);
        chk("t2_trig_low", trigger, 1'b0);
        tick(299);
        chk("t2_timeout_early", rng.timeout, 1'b0);
        tick(1);
        chk("t2_timeout", rng.timeout, 1'b1);
        chk("t2_no_valid", rng.valid, 1'b0);
        chk("t2_dist_hold", rng.distance_cm, 25);
        chk("t2_idle", rng.busy, 1'b0);
        tick(1);
        chk("t2_timeout_pulse", rng.timeout, 1'b0);
        wait_trig("t3_trig_gap", 1694);
        measure("t3_sat", 1500, SAT_CM, 1'b1);
        wait_trig("t3_trig_gap2", 491);
        measure("t3_short", 50, SHORT_CM, 1'b0);
        wait_trig("t4_trig_gap", 1941);
        tick(5);
        echo = 1'b1;
        tick(20);
        chk("t4_busy_measure", rng.busy, 1'b1);
        reset = 1'b1;
        tick(1);
        chk("t4_trigger", trigger, 1'b0);
        chk("t4_busy", rng.busy, 1'b0);
        chk("t4_valid", rng.valid, 1'b0);
        chk("t4_dist", rng.distance_cm, 0);
        chk("t4_oor", rng.out_of_range, 1'b0);
        reset = 1'b0;
        echo = 1'b0;
        tick(1);
        chk("t4_retrigger", trigger, 1'b1);
        tick(5);
        echo = 1'b1;
        tick(20);
        rng.enable = 1'b0;
        tick(1);
        chk("t5_trigger", trigger, 1'b0);
        chk("t5_busy", rng.busy, 1'b0);
        echo = 1'b0;
        tick(10);
        chk("t5_valid", rng.valid, 1'b0);
        chk("t5_dist_hold", rng.distance_cm, 0);
        rng.enable = 1'b1;
        tick(1);
        chk("t5_retrigger", trigger, 1'b1);
        for (int i = 0; i < 4; i++) begin
            measure("t6_avg", (i + 1) * 100, AVG_CM[i], 1'b0);
            if (i < 3) wait_trig("t6_trig_gap", 1991 - (i + 1) * 100);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
